simple_single_cpu: RTL and testbench

SIMPLE_SINGLE_CPU -- requirements
Module: simple_single_cpu

---
 rtl/simple_single_cpu_pkg.sv | 34 +++
 rtl/instr_mem.sv | 30 +++
 rtl/reg_file.sv | 38 +++
 rtl/simple_single_cpu.sv | 189 ++++++++++++++++++
 tb/tb_simple_single_cpu.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_single_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_single_cpu_pkg
// Brief    : Opcode/funct encodings and ALU operation enum for simple_single_cpu
// Revision : 1.0 - initial release
// ============================================================================
package simple_single_cpu_pkg;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_sltiu = 6'h0B;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_lui   = 6'h0F;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_SLTU = 3'd5,
    ALU_LUI  = 3'd6
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem
// Brief    : Instruction store with combinational read; contents are never reset
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem #(
  parameter int WORDS = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] Instr_Mem [0:WORDS-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      Instr_Mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = Instr_Mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Brief    : 32-entry register file, two async reads, one sync write, r0 fixed 0
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr_a,
  input  logic [4:0]      i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] Reg_File [0:31];

  // Reset wins over a pending write so an interrupted instruction leaves no trace
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) begin
        Reg_File[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      Reg_File[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : Reg_File[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : Reg_File[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/simple_single_cpu.sv
`default_nettype none
// ============================================================================
// Module   : simple_single_cpu
// Brief    : Single-cycle MIPS-subset CPU; define SIMPLE_SINGLE_CPU_BNE_EN to
//            add the bne instruction
// Revision : 1.0 - initial release
// ============================================================================
module simple_single_cpu
  import simple_single_cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 32,
  parameter int XLEN       = 32
) (
  input logic clk_i,
  input logic rst_i
);

  localparam int c_aw = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  logic [31:0]     r_pc;
  logic [31:0]     w_instr;
  logic [c_aw-1:0] w_fetch_word;
  logic [c_aw-1:0] w_fetch_idx;

  assign w_fetch_word = r_pc[c_aw+1:2];

  generate
    if ((1 << c_aw) == IMEM_WORDS) begin : g_pow2_wrap
      assign w_fetch_idx = w_fetch_word;
    end else begin : g_mod_wrap
      // Word slice is below 2*IMEM_WORDS, so one conditional subtract is a full modulo
      assign w_fetch_idx = (w_fetch_word >= c_aw'(IMEM_WORDS)) ?
                           (w_fetch_word - c_aw'(IMEM_WORDS)) : w_fetch_word;
    end
  endgenerate

  instr_mem #(
    .WORDS (IMEM_WORDS),
    .AW    (c_aw)
  ) IM (
    .i_clk   (clk_i),
    .i_we    (1'b0),
    .i_waddr ('0),
    .i_wdata ('0),
    .i_raddr (w_fetch_idx),
    .o_rdata (w_instr)
  );

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic        w_unused_shamt;

  assign w_opcode       = w_instr[31:26];
  assign w_rs           = w_instr[25:21];
  assign w_rt           = w_instr[20:16];
  assign w_rd           = w_instr[15:11];
  assign w_imm          = w_instr[15:0];
  assign w_funct        = w_instr[5:0];
  assign w_unused_shamt = ^w_instr[10:6];

  alu_op_e    w_alu_op;
  logic       w_use_imm;
  logic       w_zext_imm;
  logic       w_reg_we;
  logic [4:0] w_waddr;
  logic       w_is_beq;
  logic       w_is_bne;

  always_comb begin
    w_alu_op   = ALU_ADD;
    w_use_imm  = 1'b0;
    w_zext_imm = 1'b0;
    w_reg_we   = 1'b0;
    w_waddr    = w_rd;
    w_is_beq   = 1'b0;
    w_is_bne   = 1'b0;
    case (w_opcode)
      c_op_rtype: begin
        w_reg_we = 1'b1;
        case (w_funct)
          c_fn_add: w_alu_op = ALU_ADD;
          c_fn_sub: w_alu_op = ALU_SUB;
          c_fn_and: w_alu_op = ALU_AND;
          c_fn_or:  w_alu_op = ALU_OR;
          c_fn_slt: w_alu_op = ALU_SLT;
          default:  w_reg_we = 1'b0;
        endcase
      end
      c_op_addi: begin
        w_alu_op  = ALU_ADD;
        w_use_imm = 1'b1;
        w_reg_we  = 1'b1;
        w_waddr   = w_rt;
      end
      c_op_sltiu: begin
        w_alu_op  = ALU_SLTU;
        w_use_imm = 1'b1;
        w_reg_we  = 1'b1;
        w_waddr   = w_rt;
      end
      c_op_ori: begin
        w_alu_op   = ALU_OR;
        w_use_imm  = 1'b1;
        w_zext_imm = 1'b1;
        w_reg_we   = 1'b1;
        w_waddr    = w_rt;
      end
      c_op_lui: begin
        w_alu_op = ALU_LUI;
        w_reg_we = 1'b1;
        w_waddr  = w_rt;
      end
      c_op_beq: w_is_beq = 1'b1;
`ifdef SIMPLE_SINGLE_CPU_BNE_EN
      c_op_bne: w_is_bne = 1'b1;
`else
      c_op_bne: ;
`endif
      default: ;
    endcase
  end

  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic [XLEN-1:0] w_simm;
  logic [XLEN-1:0] w_zimm;
  logic [XLEN-1:0] w_lui;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_y;

  reg_file #(
    .XLEN (XLEN)
  ) RF (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_we      (w_reg_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_alu_y),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_val),
    .o_rdata_b (w_rt_val)
  );

  assign w_simm = XLEN'($signed(w_imm));
  assign w_zimm = XLEN'(w_imm);
  assign w_lui  = XLEN'({w_imm, 16'h0000});
  assign w_op_b = w_use_imm ? (w_zext_imm ? w_zimm : w_simm) : w_rt_val;

  always_comb begin
    w_alu_y = '0;
    case (w_alu_op)
      ALU_ADD:  w_alu_y = w_rs_val + w_op_b;
      ALU_SUB:  w_alu_y = w_rs_val - w_op_b;
      ALU_AND:  w_alu_y = w_rs_val & w_op_b;
      ALU_OR:   w_alu_y = w_rs_val | w_op_b;
      ALU_SLT:  w_alu_y = XLEN'($signed(w_rs_val) < $signed(w_op_b));
      ALU_SLTU: w_alu_y = XLEN'(w_rs_val < w_op_b);
      ALU_LUI:  w_alu_y = w_lui;
      default:  w_alu_y = '0;
    endcase
  end

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_target;
  logic        w_eq;
  logic        w_take;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_off    = 32'($signed(w_imm)) << 2;
  assign w_br_target = w_pc_plus4 + w_br_off;
  assign w_eq        = (w_rs_val == w_rt_val);
  assign w_take      = (w_is_beq && w_eq) || (w_is_bne && !w_eq);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_take ? w_br_target : w_pc_plus4;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simple_single_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_single_cpu
// Brief    : Directed and random-program checks of simple_single_cpu against an
//            instruction-level interpreter
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_single_cpu;

  localparam int IMEM_WORDS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] prog  [0:IMEM_WORDS-1];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_pc;

  simple_single_cpu #(
    .IMEM_WORDS (IMEM_WORDS),
    .XLEN       (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k, a, b, c;
    logic [31:0] w;
    k = int'($urandom_range(0, 12));
    a = int'($urandom_range(0, 7));
    b = int'($urandom_range(0, 7));
    c = int'($urandom_range(0, 7));
    case (k)
      0:  w = enc_r(6'h20, c, a, b);
      1:  w = enc_r(6'h22, c, a, b);
      2:  w = enc_r(6'h24, c, a, b);
      3:  w = enc_r(6'h25, c, a, b);
      4:  w = enc_r(6'h2A, c, a, b);
      5:  w = enc_i(6'h08, b, a, int'($urandom));
      6:  w = enc_i(6'h0B, b, a, int'($urandom));
      7:  w = enc_i(6'h0D, b, a, int'($urandom));
      8:  w = enc_i(6'h0F, b, a, int'($urandom));
      9:  w = enc_i(6'h04, b, a, int'($urandom_range(0, 6)) - 3);
      10: w = enc_i(6'h05, b, a, int'($urandom_range(0, 6)) - 3);
      11: w = $urandom;
      default: w = enc_r(6'h27, c, a, b);
    endcase
    return w;
  endfunction

  // Instruction-set interpreter: one call retires one instruction
  task automatic model_step();
    logic [31:0] ins, a, b, simm, npc, val;
    int wr;
    ins  = prog[(m_pc >> 2) % IMEM_WORDS];
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    npc  = m_pc + 32'd4;
    wr   = 0;
    val  = '0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: begin wr = int'(ins[15:11]); val = a + b; end
          6'h22: begin wr = int'(ins[15:11]); val = a - b; end
          6'h24: begin wr = int'(ins[15:11]); val = a & b; end
          6'h25: begin wr = int'(ins[15:11]); val = a | b; end
          6'h2A: begin wr = int'(ins[15:11]); val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          default: ;
        endcase
      end
      6'h08: begin wr = int'(ins[20:16]); val = a + simm; end
      6'h0B: begin wr = int'(ins[20:16]); val = (a < simm) ? 32'd1 : 32'd0; end
      6'h0D: begin wr = int'(ins[20:16]); val = a | {16'h0000, ins[15:0]}; end
      6'h0F: begin wr = int'(ins[20:16]); val = {ins[15:0], 16'h0000}; end
      6'h04: if (a == b) npc = m_pc + 32'd4 + (simm << 2);
`ifdef SIMPLE_SINGLE_CPU_BNE_EN
      6'h05: if (a != b) npc = m_pc + 32'd4 + (simm << 2);
`endif
      default: ;
    endcase
    if (wr != 0) m_reg[wr] = val;
    m_pc = npc;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk($sformatf("%s_pc", tag), dut.r_pc, m_pc);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_r%0d", tag, i), dut.RF.Reg_File[i], m_reg[i]);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IMEM_WORDS; i++) prog[i] = 32'h0;
  endtask

  // Hold reset for n rising edges with the current program loaded; leaves rst high
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < IMEM_WORDS; i++) dut.IM.Instr_Mem[i] = prog[i];
    repeat (n) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
    end
    #1;
  endtask

  initial begin
    // Reset state with the arithmetic program loaded
    clear_prog();
    prog[0] = enc_i(6'h08, 1, 0, 5);
    prog[1] = enc_i(6'h08, 2, 0, -3);
    prog[2] = enc_r(6'h20, 3, 1, 2);
    prog[3] = enc_r(6'h22, 4, 1, 2);
    apply_reset(2);
    chk("reset_pc", dut.r_pc, 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("reset_r%0d", i), dut.RF.Reg_File[i], 32'h0);

    release_reset();
    run(4);
    chk("arith_r1", dut.RF.Reg_File[1], 32'd5);
    chk("arith_r2", dut.RF.Reg_File[2], 32'hFFFF_FFFD);
    chk("arith_r3", dut.RF.Reg_File[3], 32'd2);
    chk("arith_r4", dut.RF.Reg_File[4], 32'd8);
    chk("arith_pc", dut.r_pc, 32'd16);

    // Reset arriving while the second instruction is pending
    apply_reset(1);
    release_reset();
    run(1);
    chk("midrst_pre_r1", dut.RF.Reg_File[1], 32'd5);
    apply_reset(1);
    chk("midrst_r1", dut.RF.Reg_File[1], 32'd0);
    chk("midrst_r2", dut.RF.Reg_File[2], 32'd0);
    chk("midrst_pc", dut.r_pc, 32'd0);

    clear_prog();
    prog[0] = enc_i(6'h08, 1, 0, 5);
    prog[1] = enc_i(6'h0B, 5, 1, 7);
    prog[2] = enc_i(6'h0B, 6, 1, -1);
    prog[3] = enc_i(6'h0B, 7, 1, 3);
    apply_reset(1);
    release_reset();
    run(4);
    chk("sltiu_r5", dut.RF.Reg_File[5], 32'd1);
    chk("sltiu_r6", dut.RF.Reg_File[6], 32'd1);
    chk("sltiu_r7", dut.RF.Reg_File[7], 32'd0);

    clear_prog();
    prog[0] = enc_i(6'h08, 1, 0, -1);
    prog[1] = enc_i(6'h08, 2, 0, 1);
    prog[2] = enc_r(6'h2A, 8, 1, 2);
    prog[3] = enc_r(6'h24, 9, 1, 2);
    prog[4] = enc_r(6'h25, 10, 1, 2);
    apply_reset(1);
    release_reset();
    run(5);
    chk("slt_r8", dut.RF.Reg_File[8], 32'd1);
    chk("and_r9", dut.RF.Reg_File[9], 32'd1);
    chk("or_r10", dut.RF.Reg_File[10], 32'hFFFF_FFFF);
    chk("logic_pc", dut.r_pc, 32'd20);

    // beq always taken skips one word; bne r0,r0 is never taken in either build
    clear_prog();
    prog[0] = enc_i(6'h04, 0, 0, 1);
    prog[1] = enc_i(6'h08, 11, 0, 9);
    prog[2] = enc_i(6'h08, 12, 0, 4);
    prog[3] = enc_i(6'h05, 0, 0, 1);
    prog[4] = enc_i(6'h08, 13, 0, 6);
    apply_reset(1);
    release_reset();
    run(4);
    chk("beq_r11", dut.RF.Reg_File[11], 32'd0);
    chk("beq_r12", dut.RF.Reg_File[12], 32'd4);
    chk("bne_r13", dut.RF.Reg_File[13], 32'd6);
    chk("branch_pc", dut.r_pc, 32'd20);

    clear_prog();
    prog[0] = enc_i(6'h08, 0, 0, 7);
    prog[1] = enc_i(6'h0F, 1, 0, 32'h1234);
    prog[2] = enc_i(6'h0D, 1, 1, 32'h5678);
    apply_reset(1);
    release_reset();
    run(3);
    chk("r0_fixed", dut.RF.Reg_File[0], 32'd0);
    chk("luiori_r1", dut.RF.Reg_File[1], 32'h1234_5678);

    // Fetch wraps after IMEM_WORDS words while the PC keeps counting
    clear_prog();
    prog[0] = enc_i(6'h08, 1, 1, 1);
    apply_reset(1);
    release_reset();
    run(IMEM_WORDS + 1);
    chk("wrap_r1", dut.RF.Reg_File[1], 32'd2);
    chk("wrap_pc", dut.r_pc, 32'(4 * (IMEM_WORDS + 1)));

    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < IMEM_WORDS; i++) prog[i] = rand_instr();
      apply_reset(1);
      release_reset();
      for (int c = 0; c < 64; c++) begin
        @(posedge clk);
        model_step();
        #1;
        chk_model($sformatf("rand%0d_c%0d", p, c));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
